tms320c1x_host_bridge: RTL

Host-side responder for the TMS320C1X core's external I/O port bus. It answers the DSP's IN/OUT port reads and writes and turns them into word transactions on the main-CPU memory bus, using an auto-incrementing address pointer and a one-word read prefetch. It stalls the DSP through its `EN` input while a transaction is in flight. It also gives the main CPU a small register window to control the DSP: run/reset, the BIO flag, interrupt pulse, and a mailbox.

---
 rtl/tms320c1x_host_bridge_if.sv | 42 ++++
 rtl/tms320c1x_host_bridge.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tms320c1x_host_bridge_if.sv
// Signal bundle between the TMS320C1X port bus, the main-CPU register window
// and the host memory bus. The bridge uses the slave side; the environment uses the master side.
interface tms320c1x_host_bridge_if #(
    parameter int HOST_AW = 20
);
    logic [2:0]         DSP_A;
    logic [15:0]        DSP_DO;
    logic [15:0]        DSP_DI;
    logic               DSP_WE_N;
    logic               DSP_DEN_N;
    logic               DSP_EN;
    logic               DSP_RS_N;
    logic               DSP_BIO_N;
    logic               DSP_INT_N;
    logic               HOST_CS;
    logic               HOST_WR;
    logic [1:0]         HOST_ADDR;
    logic [15:0]        HOST_DIN;
    logic [15:0]        HOST_DOUT;
    logic [HOST_AW-1:0] MEM_ADDR;
    logic [15:0]        MEM_DOUT;
    logic [15:0]        MEM_DIN;
    logic               MEM_RD;
    logic               MEM_WR;
    logic               MEM_ACK;

    modport slave (
        input  DSP_A, DSP_DO, DSP_WE_N, DSP_DEN_N,
        input  HOST_CS, HOST_WR, HOST_ADDR, HOST_DIN,
        input  MEM_DIN, MEM_ACK,
        output DSP_DI, DSP_EN, DSP_RS_N, DSP_BIO_N, DSP_INT_N,
        output HOST_DOUT, MEM_ADDR, MEM_DOUT, MEM_RD, MEM_WR
    );

    modport master (
        output DSP_A, DSP_DO, DSP_WE_N, DSP_DEN_N,
        output HOST_CS, HOST_WR, HOST_ADDR, HOST_DIN,
        output MEM_DIN, MEM_ACK,
        input  DSP_DI, DSP_EN, DSP_RS_N, DSP_BIO_N, DSP_INT_N,
        input  HOST_DOUT, MEM_ADDR, MEM_DOUT, MEM_RD, MEM_WR
    );
endinterface

// File: rtl/tms320c1x_host_bridge.sv
// TMS320C1X I/O-port responder: auto-incrementing pointer into host memory with a
// one-word read prefetch, DSP stall while the bus is busy, and a host control window.
module tms320c1x_host_bridge #(
    parameter int HOST_AW = 20,
    parameter int INT_LEN = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    tms320c1x_host_bridge_if.slave  bus
);
    localparam int CW = $clog2(INT_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_e;

    state_e             state_q, state_d;
    logic               we_n_q, den_n_q;
    logic [HOST_AW-1:0] ptr_q, ptr_d, mem_addr_q, mem_addr_d, ptr_inc;
    logic [15:0]        pref_q, pref_d, mbox_q, mbox_d, mem_dout_q, mem_dout_d;
    logic               flag_q, flag_d, run_q, run_d, bio_q, bio_d;
    logic               mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [CW-1:0]      int_cnt_q, int_cnt_d;
    logic               busy, wr_evt, rd_evt, host_we;

    assign busy    = (state_q != S_IDLE);
    assign ptr_inc = ptr_q + {{(HOST_AW-1){1'b0}}, 1'b1};
    // Strobe edges arriving while busy are dropped; the stalled core cannot produce them.
    assign wr_evt  = !busy && !bus.DSP_WE_N && we_n_q;
    assign rd_evt  = !busy && !bus.DSP_DEN_N && den_n_q;
    assign host_we = bus.HOST_CS && bus.HOST_WR;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pref_d     = pref_q;
        mbox_d     = mbox_q;
        flag_d     = flag_q;
        run_d      = run_q;
        bio_d      = bio_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        int_cnt_d  = (int_cnt_q != '0) ? int_cnt_q - CW'(1) : '0;

        if (host_we) begin
            case (bus.HOST_ADDR)
                2'd0: begin
                    run_d = bus.HOST_DIN[0];
                    bio_d = bus.HOST_DIN[1];
                end
                2'd1:    flag_d    = 1'b0;
                2'd2:    int_cnt_d = CW'(INT_LEN);
                default: ;
            endcase
        end

        if (busy && bus.MEM_ACK) begin
            state_d  = S_IDLE;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            if (state_q == S_RD) pref_d = bus.MEM_DIN;
        end

        // DSP events come after the host clear so a same-cycle mailbox write keeps FLAG set.
        if (wr_evt) begin
            case (bus.DSP_A)
                3'd0: begin
                    ptr_d[15:0] = bus.DSP_DO;
                    mem_addr_d  = {ptr_q[HOST_AW-1:16], bus.DSP_DO};
                    mem_rd_d    = 1'b1;
                    state_d     = S_RD;
                end
                3'd1: begin
                    mem_addr_d = ptr_q;
                    mem_dout_d = bus.DSP_DO;
                    ptr_d      = ptr_inc;
                    mem_wr_d   = 1'b1;
                    state_d    = S_WR;
                end
                3'd2: begin
                    ptr_d[HOST_AW-1:16] = bus.DSP_DO[HOST_AW-17:0];
                    mem_addr_d          = {bus.DSP_DO[HOST_AW-17:0], ptr_q[15:0]};
                    mem_rd_d            = 1'b1;
                    state_d             = S_RD;
                end
                3'd3: begin
                    mbox_d = bus.DSP_DO;
                    flag_d = 1'b1;
                end
                default: ;
            endcase
        end else if (rd_evt && bus.DSP_A == 3'd1) begin
            ptr_d      = ptr_inc;
            mem_addr_d = ptr_inc;
            mem_rd_d   = 1'b1;
            state_d    = S_RD;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            we_n_q     <= 1'b1;
            den_n_q    <= 1'b1;
            ptr_q      <= '0;
            pref_q     <= '0;
            mbox_q     <= '0;
            flag_q     <= 1'b0;
            run_q      <= 1'b0;
            bio_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            int_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            we_n_q     <= bus.DSP_WE_N;
            den_n_q    <= bus.DSP_DEN_N;
            ptr_q      <= ptr_d;
            pref_q     <= pref_d;
            mbox_q     <= mbox_d;
            flag_q     <= flag_d;
            run_q      <= run_d;
            bio_q      <= bio_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            int_cnt_q  <= int_cnt_d;
        end
    end

    always_comb begin
        case (bus.DSP_A)
            3'd0:    bus.DSP_DI = ptr_q[15:0];
            3'd1:    bus.DSP_DI = pref_q;
            3'd3:    bus.DSP_DI = {14'b0, busy, flag_q};
            default: bus.DSP_DI = 16'h0000;
        endcase
        case (bus.HOST_ADDR)
            2'd0:    bus.HOST_DOUT = {14'b0, bio_q, run_q};
            2'd1:    bus.HOST_DOUT = {14'b0, busy, flag_q};
            2'd3:    bus.HOST_DOUT = mbox_q;
            default: bus.HOST_DOUT = 16'h0000;
        endcase
    end

    assign bus.DSP_EN    = !busy;
    assign bus.DSP_RS_N  = run_q;
    assign bus.DSP_BIO_N = !bio_q;
    assign bus.DSP_INT_N = (int_cnt_q == '0);
    assign bus.MEM_ADDR  = mem_addr_q;
    assign bus.MEM_DOUT  = mem_dout_q;
    assign bus.MEM_RD    = mem_rd_q;
    assign bus.MEM_WR    = mem_wr_q;
endmodule
